// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter generator.
// Steps the fetch PC by INC, supports stall, branch/jump redirect, trap
// redirect, buffering of a redirect that arrives during a stall, and a
// shift-register history of recently issued PCs.
//
// Ports:
//   cpu_clk          clock, all state changes on the rising edge
//   reset            synchronous active-high reset
//   count_enb        advance enable (0 = fetch stall)
//   redirect_valid   branch/jump taken this cycle
//   redirect_addr    branch/jump target
//   trap_valid       trap/exception redirect
//   trap_vec         trap handler address
//   pc               current fetch PC (registered)
//   pc_next          value pc loads at the next edge (combinational)
//   pc_hist          PC history, stage 0 (newest) in bits [XLEN-1:0]
//   hist_valid       per-stage history valid bits
//   redirect_pending a buffered redirect is waiting for the stall to lift
//   misaligned       one-cycle pulse: last applied target had low bits set
module pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000,
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     PIPE_DEPTH = 3
) (
  input  logic                       cpu_clk,
  input  logic                       reset,
  input  logic                       count_enb,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_addr,
  input  logic                       trap_valid,
  input  logic [XLEN-1:0]            trap_vec,
  output logic [XLEN-1:0]            pc,
  output logic [XLEN-1:0]            pc_next,
  output logic [PIPE_DEPTH*XLEN-1:0] pc_hist,
  output logic [PIPE_DEPTH-1:0]      hist_valid,
  output logic                       redirect_pending,
  output logic                       misaligned
);

  // Bits that must be zero in any applied target; all-zero when ALIGN_BITS=0.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

  logic [XLEN-1:0] pend_addr;
  logic [XLEN-1:0] hist_q [PIPE_DEPTH];

  logic            apply_c;
  logic            store_c;
  logic            advance_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_calc_c;
  logic            mis_c;

  // Next-PC selection in priority order: trap, live redirect, stalled
  // redirect capture, pending redirect, sequential advance, hold.
  always_comb begin
    apply_c   = 1'b0;
    store_c   = 1'b0;
    advance_c = 1'b0;
    target_c  = pend_addr;
    pc_calc_c = pc;
    mis_c     = 1'b0;

    if (trap_valid) begin
      apply_c  = 1'b1;
      target_c = trap_vec;
    end else if (redirect_valid && count_enb) begin
      apply_c  = 1'b1;
      target_c = redirect_addr;
    end else if (redirect_valid) begin
      store_c = 1'b1;
    end else if (redirect_pending && count_enb) begin
      apply_c  = 1'b1;
      target_c = pend_addr;
    end else if (count_enb) begin
      advance_c = 1'b1;
      pc_calc_c = pc + XLEN'(INC);
    end

    // Alignment check runs only when a target is actually loaded.
    if (apply_c) begin
      pc_calc_c = target_c & ~ALIGN_MASK;
      mis_c     = |(target_c & ALIGN_MASK);
    end

    pc_next = reset ? RESET_VEC : pc_calc_c;
  end

  // PC, pending redirect, history and alignment flag.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      pc               <= RESET_VEC;
      pend_addr        <= '0;
      redirect_pending <= 1'b0;
      hist_valid       <= '0;
      misaligned       <= 1'b0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      pc         <= pc_calc_c;
      misaligned <= mis_c;
      if (apply_c) begin
        // Any applied target flushes the history valids.
        redirect_pending <= 1'b0;
        hist_valid       <= '0;
      end else if (store_c) begin
        // Newer stalled redirect overwrites the buffered one; raw address kept.
        pend_addr        <= redirect_addr;
        redirect_pending <= 1'b1;
      end else if (advance_c) begin
        hist_q[0]     <= pc;
        hist_valid[0] <= 1'b1;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
          hist_q[i]     <= hist_q[i-1];
          hist_valid[i] <= hist_valid[i-1];
        end
      end
    end
  end

  // Flatten history, stage 0 in the low bits.
  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_hist
    assign pc_hist[g*XLEN +: XLEN] = hist_q[g];
  end

endmodule
